// File: rtl/rv_multicycle_core.sv
// Multi-cycle RV32I/RV64I integer core: FETCH/DECODE/EXEC/WB sequencer, shift-add MUL, write-loadable ROM.
// Faults and ECALL/EBREAK park the core in HALT; run restarts it from RESET_PC while keeping the register file.
module rv_multicycle_core #(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 32,
    parameter int NUM_REGS   = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic                          busy,
    output logic                          halted,
    output logic                          trap,
    output logic [XLEN-1:0]               pc,
    output logic                          wb_valid,
    output logic [4:0]                    wb_rd,
    output logic [XLEN-1:0]               wb_data,
    output logic [31:0]                   retired
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int SW = $clog2(XLEN);
    localparam int RW = $clog2(NUM_REGS);

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011, OP_SYS = 7'b1110011;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MUL, S_WB, S_HALT} state_t;
    state_t state, state_nxt;

    logic [31:0]     imem [IMEM_DEPTH];
    logic [XLEN-1:0] regs [NUM_REGS];
    logic [XLEN-1:0] pc_q, npc_q, a, b, imm, wb_data_q;
    logic [XLEN-1:0] mcand, mplier, acc, acc_nxt;
    logic [SW-1:0]   mul_cnt;
    logic [31:0]     ir, retired_q;
    logic [4:0]      wb_rd_q;
    logic            trap_q;

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rd_idx, rs1_idx, rs2_idx;
    logic [31:0] imm_dec;
    logic        use_rd, use_rs1, use_rs2, legal, is_sys, is_mul, sh_ok, reg_bad, fault;

    assign opcode  = ir[6:0];
    assign rd_idx  = ir[11:7];
    assign f3      = ir[14:12];
    assign rs1_idx = ir[19:15];
    assign rs2_idx = ir[24:20];
    assign f7      = ir[31:25];
    // For RV32 the shamt field is 5 bits, so ir[25] must be clear as well.
    assign sh_ok = (ir[31:26] == 6'b000000 || (f3 == 3'b101 && ir[31:26] == 6'b010000))
                   && (XLEN == 64 || !ir[25]);

    always_comb begin
        use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
        legal = 1'b0; is_sys = 1'b0; is_mul = 1'b0; imm_dec = '0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin use_rd = 1'b1; legal = 1'b1; imm_dec = {ir[31:12], 12'b0}; end
            OP_JAL: begin
                use_rd = 1'b1; legal = 1'b1;
                imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            OP_JALR: begin
                use_rd = 1'b1; use_rs1 = 1'b1; legal = (f3 == 3'b000);
                imm_dec = {{20{ir[31]}}, ir[31:20]};
            end
            OP_BR: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; legal = (f3 != 3'b010 && f3 != 3'b011);
                imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            end
            OP_IMM: begin
                use_rd = 1'b1; use_rs1 = 1'b1; imm_dec = {{20{ir[31]}}, ir[31:20]};
                legal = (f3 == 3'b001 || f3 == 3'b101) ? sh_ok : 1'b1;
            end
            OP_REG: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                is_mul = (f7 == 7'b0000001 && f3 == 3'b000);
                legal  = (f7 == 7'b0000000) || is_mul ||
                         (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            end
            OP_SYS: begin is_sys = 1'b1; legal = 1'b1; end
            default: ;
        endcase
    end

    assign reg_bad = (use_rd  && 32'(rd_idx)  >= NUM_REGS) ||
                     (use_rs1 && 32'(rs1_idx) >= NUM_REGS) ||
                     (use_rs2 && 32'(rs2_idx) >= NUM_REGS);

    logic [XLEN-1:0] op2, alu_res, exec_res, exec_npc, pc4;
    logic [SW-1:0]   shamt;
    logic            take, xfer;

    assign op2   = (opcode == OP_REG) ? b : imm;
    assign shamt = op2[SW-1:0];
    assign pc4   = pc_q + XLEN'(4);

    always_comb begin
        alu_res = '0;
        case (f3)
            3'b000: alu_res = (opcode == OP_REG && ir[30]) ? a - op2 : a + op2;
            3'b001: alu_res = a << shamt;
            3'b010: alu_res = XLEN'($signed(a) < $signed(op2));
            3'b011: alu_res = XLEN'(a < op2);
            3'b100: alu_res = a ^ op2;
            3'b101: alu_res = ir[30] ? XLEN'($signed(a) >>> shamt) : a >> shamt;
            3'b110: alu_res = a | op2;
            default: alu_res = a & op2;
        endcase
        case (f3)
            3'b000: take = (a == b);
            3'b001: take = (a != b);
            3'b100: take = ($signed(a) < $signed(b));
            3'b101: take = ($signed(a) >= $signed(b));
            3'b110: take = (a < b);
            3'b111: take = (a >= b);
            default: take = 1'b0;
        endcase
        exec_res = alu_res; exec_npc = pc4; xfer = 1'b0;
        case (opcode)
            OP_LUI:   exec_res = imm;
            OP_AUIPC: exec_res = pc_q + imm;
            OP_JAL:   begin exec_res = pc4; exec_npc = pc_q + imm; xfer = 1'b1; end
            OP_JALR:  begin exec_res = pc4; exec_npc = (a + imm) & ~XLEN'(1); xfer = 1'b1; end
            OP_BR: begin
                exec_res = '0;
                if (take) begin exec_npc = pc_q + imm; xfer = 1'b1; end
            end
            default: ;
        endcase
    end

    assign fault   = !legal || reg_bad || (xfer && exec_npc[1]);
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HALT: if (run) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (fault || is_sys) state_nxt = S_HALT;
                else if (is_mul)     state_nxt = S_MUL;
                else                 state_nxt = S_WB;
            end
            S_MUL:   if (mul_cnt == SW'(XLEN - 1)) state_nxt = S_WB;
            S_WB:    state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Program memory is deliberately left out of reset so a loaded image survives rst.
    always_ff @(posedge clk) begin
        if (imem_we && (state == S_IDLE || state == S_HALT)) imem[imem_waddr] <= imem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC; npc_q <= '0; a <= '0; b <= '0; imm <= '0; ir <= '0;
            wb_data_q <= '0; wb_rd_q <= '0; trap_q <= 1'b0; retired_q <= '0;
            mcand <= '0; mplier <= '0; acc <= '0; mul_cnt <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: if (run) begin
                    pc_q <= RESET_PC; trap_q <= 1'b0; retired_q <= '0;
                end
                S_FETCH: ir <= imem[pc_q[AW+1:2]];
                S_DECODE: begin
                    a   <= regs[rs1_idx[RW-1:0]];
                    b   <= regs[rs2_idx[RW-1:0]];
                    imm <= XLEN'($signed(imm_dec));
                end
                S_EXEC: begin
                    if (fault) trap_q <= 1'b1;
                    else if (!is_sys) begin
                        npc_q   <= exec_npc;
                        wb_rd_q <= use_rd ? rd_idx : 5'd0;
                        if (is_mul) begin
                            acc <= '0; mcand <= a; mplier <= b; mul_cnt <= '0;
                        end else begin
                            wb_data_q <= exec_res;
                        end
                    end
                end
                S_MUL: begin
                    acc     <= acc_nxt;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    mul_cnt <= mul_cnt + SW'(1);
                    if (mul_cnt == SW'(XLEN - 1)) wb_data_q <= acc_nxt;
                end
                S_WB: begin
                    if (wb_rd_q != 5'd0) regs[wb_rd_q[RW-1:0]] <= wb_data_q;
                    retired_q <= retired_q + 32'd1;
                    pc_q      <= npc_q;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != S_IDLE) && (state != S_HALT);
    assign halted   = (state == S_HALT);
    assign trap     = trap_q;
    assign pc       = pc_q;
    assign wb_valid = (state == S_WB);
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign retired  = retired_q;
endmodule

// File: tb/tb_rv_multicycle_core.sv
// Directed bench for rv_multicycle_core (XLEN=32, NUM_REGS=16) against an instruction-level reference model.
module tb_rv_multicycle_core;
    localparam int NR = 16;

    logic        clk = 1'b0, rst = 1'b1, run = 1'b0, imem_we = 1'b0;
    logic [4:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    logic        busy, halted, trap, wb_valid;
    logic [31:0] pc, wb_data, retired;
    logic [4:0]  wb_rd;

    rv_multicycle_core #(.XLEN(32), .IMEM_DEPTH(32), .NUM_REGS(NR), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .run(run), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .busy(busy), .halted(halted), .trap(trap), .pc(pc),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .retired(retired)
    );

    always #5 clk = ~clk;

    int n_total = 0, n_bad = 0;
    int cyc = 0, base = 0;
    bit chk_on = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_imem [32];
    logic [31:0] m_regs [32];
    logic [31:0] prog   [32];
    logic [31:0] q_rd[$], q_data[$], q_pc[$], q_cyc[$];
    logic [31:0] m_retired, m_halt_pc, m_halt_cyc;
    logic        m_trap;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    function automatic logic [31:0] e_i(input int imm, input int rs1, input int f3, input int rd,
                                        input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] e_r(input int f7, input int rs2, input int rs1, input int f3,
                                        input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] e_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] e_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                                        input bit alt);
        case (f3)
            3'd0: return alt ? x - y : x + y;
            3'd1: return x << y[4:0];
            3'd2: return {31'b0, $signed(x) < $signed(y)};
            3'd3: return {31'b0, x < y};
            3'd4: return x ^ y;
            3'd5: return alt ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    // Executes the loaded program instruction by instruction, recording every retirement.
    task automatic model_run();
        logic [31:0] p, ins, a, b, ii, res, npc;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        bit legal, urd, urs1, urs2, xfer, mul, sys, bad, done;
        int c, lat, steps;
        p = 32'h0; c = 0; steps = 0; done = 1'b0; m_retired = 0; m_trap = 1'b0;
        q_rd.delete(); q_data.delete(); q_pc.delete(); q_cyc.delete();
        while (!done && steps < 64) begin
            steps++;
            ins = m_imem[p[6:2]];
            op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; rs1 = ins[19:15]; rs2 = ins[24:20];
            f7 = ins[31:25];
            a = m_regs[rs1]; b = m_regs[rs2]; ii = {{20{ins[31]}}, ins[31:20]};
            legal = 1'b0; urd = 1'b0; urs1 = 1'b0; urs2 = 1'b0; xfer = 1'b0; mul = 1'b0; sys = 1'b0;
            res = 32'h0; npc = p + 4;
            case (op)
                7'b0110111: begin legal = 1; urd = 1; res = {ins[31:12], 12'h0}; end
                7'b0010111: begin legal = 1; urd = 1; res = p + {ins[31:12], 12'h0}; end
                7'b1101111: begin
                    legal = 1; urd = 1; res = p + 4; xfer = 1;
                    npc = p + {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                end
                7'b1100111: begin
                    legal = (f3 == 0); urd = 1; urs1 = 1; res = p + 4; xfer = 1;
                    npc = (a + ii) & 32'hFFFF_FFFE;
                end
                7'b1100011: begin
                    urs1 = 1; urs2 = 1; legal = (f3 != 2 && f3 != 3);
                    case (f3)
                        0: xfer = (a == b);
                        1: xfer = (a != b);
                        4: xfer = ($signed(a) < $signed(b));
                        5: xfer = ($signed(a) >= $signed(b));
                        6: xfer = (a < b);
                        7: xfer = (a >= b);
                        default: xfer = 0;
                    endcase
                    if (xfer) npc = p + {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                end
                7'b0010011: begin
                    urd = 1; urs1 = 1;
                    if (f3 == 1)      legal = (f7 == 7'h00);
                    else if (f3 == 5) legal = (f7 == 7'h00 || f7 == 7'h20);
                    else              legal = 1;
                    res = alu(f3, a, ii, f3 == 5 && ins[30]);
                end
                7'b0110011: begin
                    urd = 1; urs1 = 1; urs2 = 1;
                    if (f7 == 7'h01) begin legal = (f3 == 0); mul = 1; res = a * b; end
                    else begin
                        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                        res = alu(f3, a, b, f7 == 7'h20);
                    end
                end
                7'b1110011: begin legal = 1; sys = 1; end
                default: ;
            endcase
            bad = !legal || (urd && rd >= NR) || (urs1 && rs1 >= NR) || (urs2 && rs2 >= NR) ||
                  (xfer && npc[1]);
            if (bad || sys) begin
                done = 1'b1; m_trap = bad; m_halt_pc = p; m_halt_cyc = c + 4;
            end else begin
                lat = mul ? 36 : 4;
                c += lat;
                q_rd.push_back(urd ? 32'(rd) : 32'h0); q_data.push_back(res);
                q_pc.push_back(p); q_cyc.push_back(c);
                if (urd && rd != 0) m_regs[rd] = res;
                p = npc; m_retired++;
            end
        end
    endtask

    // ---------------- compare process ----------------
    logic [31:0] e_rd, e_data, e_pc, e_cyc;
    always @(negedge clk) begin
        if (chk_on && wb_valid) begin
            if (q_rd.size() == 0) begin
                n_total++; n_bad++;
                $display("FAIL unexpected_retire: got wb_rd=%0d wb_data=%0h expected none", wb_rd, wb_data);
            end else begin
                e_rd = q_rd.pop_front(); e_data = q_data.pop_front();
                e_pc = q_pc.pop_front(); e_cyc = q_cyc.pop_front();
                chk("wb_rd", 32'(wb_rd), e_rd);
                chk("wb_data", wb_data, e_data);
                chk("wb_pc", pc, e_pc);
                chk("wb_cycle", 32'(cyc - base), e_cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_prog_default();
        for (int i = 0; i < 32; i++) prog[i] = EBREAK;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk); imem_we = 1'b1; imem_waddr = 5'(i); imem_wdata = prog[i];
            m_imem[i] = prog[i];
        end
        @(negedge clk); imem_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; chk_on = 1'b0; run = 1'b0; imem_we = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        q_rd.delete(); q_data.delete(); q_pc.delete(); q_cyc.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_run();
        @(negedge clk); run = 1'b1; base = cyc; chk_on = 1'b1;
        @(negedge clk); run = 1'b0;
    endtask

    task automatic wait_halt(input string nm);
        int t = 0;
        while (!halted && t < 400) begin @(negedge clk); t++; end
        chk({nm, "_halted"}, 32'(halted), 32'd1);
        chk({nm, "_halt_cycle"}, 32'(cyc - base), m_halt_cyc);
        chk({nm, "_trap"}, 32'(trap), 32'(m_trap));
        chk({nm, "_retired"}, retired, m_retired);
        chk({nm, "_halt_pc"}, pc, m_halt_pc);
        chk({nm, "_pending_retires"}, 32'(q_rd.size()), 32'd0);
        chk_on = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_halted"}, 32'(halted), 32'd0);
        chk({nm, "_trap"}, 32'(trap), 32'd0);
        chk({nm, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({nm, "_wb_rd"}, 32'(wb_rd), 32'd0);
        chk({nm, "_wb_data"}, wb_data, 32'd0);
        chk({nm, "_retired"}, retired, 32'd0);
        chk({nm, "_pc"}, pc, 32'd0);
    endtask

    initial begin
        do_reset();
        chk_reset_outputs("reset");

        // Two ADDIs then EBREAK: retires at cycles 4 and 8, halt with no trap.
        set_prog_default();
        prog[0] = e_i(5, 0, 0, 1, 7'b0010011);
        prog[1] = e_i(-7, 1, 0, 2, 7'b0010011);
        load_prog(); model_run();
        chk("pin_addi_data0", q_data[0], 32'd5);
        chk("pin_addi_data1", q_data[1], 32'hFFFF_FFFE);
        chk("pin_addi_cyc1", q_cyc[1], 32'd8);
        do_run(); wait_halt("addi");

        // MUL of 7 by -3 takes 36 cycles FETCH..WB.
        set_prog_default();
        prog[0] = e_i(7, 0, 0, 1, 7'b0010011);
        prog[1] = e_i(-3, 0, 0, 2, 7'b0010011);
        prog[2] = e_r(1, 2, 1, 0, 3);
        load_prog(); model_run();
        chk("pin_mul_data", q_data[2], 32'hFFFF_FFEB);
        chk("pin_mul_latency", q_cyc[2] - q_cyc[1], 32'd36);
        do_run(); wait_halt("mul");

        // BNE at pc 8, taken then not taken.
        for (int v = 1; v >= 0; v--) begin
            set_prog_default();
            prog[0] = e_i(v, 0, 0, 1, 7'b0010011);
            prog[1] = e_i(0, 0, 0, 2, 7'b0010011);
            prog[2] = e_b(8, 1, 0, 1);
            prog[3] = e_i(3, 0, 0, 3, 7'b0010011);
            load_prog(); model_run();
            chk("pin_br_data", q_data[2], 32'd0);
            chk("pin_br_retired", m_retired, (v == 1) ? 32'd3 : 32'd4);
            do_run(); wait_halt(v == 1 ? "bne_taken" : "bne_not_taken");
        end

        // JALR to 0x20 with link, then a misaligned JAL that must trap.
        set_prog_default();
        prog[0] = e_i(32'h20, 0, 0, 1, 7'b0010011);
        prog[1] = e_i(1, 1, 0, 5, 7'b1100111);
        prog[8] = e_j(6, 0);
        load_prog(); model_run();
        chk("pin_jalr_link", q_data[1], 32'd8);
        chk("pin_jal_trap", 32'(m_trap), 32'd1);
        chk("pin_jal_pc", m_halt_pc, 32'h20);
        do_run(); wait_halt("jump");

        // x0 stays zero; x17 is out of range for a 16-register file.
        set_prog_default();
        prog[0] = e_i(9, 0, 0, 0, 7'b0010011);
        prog[1] = e_r(0, 0, 0, 0, 4);
        prog[2] = e_r(0, 2, 1, 0, 17);
        load_prog(); model_run();
        chk("pin_x0_read", q_data[1], 32'd0);
        chk("pin_x17_trap", 32'(m_trap), 32'd1);
        do_run(); wait_halt("regidx");

        // DIV encoding is unsupported.
        set_prog_default();
        prog[0] = e_r(1, 2, 1, 4, 3);
        load_prog(); model_run();
        chk("pin_div_retired", m_retired, 32'd0);
        do_run(); wait_halt("div");

        // imem write and run while busy are both ignored; the rerun repeats the same program.
        set_prog_default();
        prog[0] = e_i(5, 0, 0, 1, 7'b0010011);
        prog[1] = e_i(-7, 1, 0, 2, 7'b0010011);
        load_prog(); model_run();
        do_run();
        @(negedge clk); imem_we = 1'b1; imem_waddr = 5'd1;
        imem_wdata = e_i(100, 1, 0, 2, 7'b0010011);
        @(negedge clk); imem_we = 1'b0;
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        wait_halt("busy_write");
        model_run(); do_run(); wait_halt("rerun");

        // Reset during cycle 10 of a MUL.
        set_prog_default();
        prog[0] = e_i(7, 0, 0, 1, 7'b0010011);
        prog[1] = e_i(-3, 0, 0, 2, 7'b0010011);
        prog[2] = e_r(1, 2, 1, 0, 3);
        load_prog(); model_run();
        do_run();
        while (cyc - base < 21) @(negedge clk);
        chk("mul_busy_before_rst", 32'(busy), 32'd1);
        chk_on = 1'b0; rst = 1'b1;
        #1 chk_reset_outputs("mid_mul_rst");
        do_reset();
        chk_reset_outputs("after_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/rv_multicycle_core.md
Name: rv_multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle integer datapath.
- A sequencer FSM fetches, decodes, executes and writes back one instruction at a time. It supports branches and jumps, and includes an iterative shift-add multiplier for MUL.
- Program memory is a write-loadable ROM.
- Sits at top level of the FPGA test build. Debug outputs are intended for ILA probing.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- IMEM_DEPTH, 32, instruction words; power of 2, ≥ 4.
- NUM_REGS, 32, architectural registers; 16 (RV32E style) or 32.
- RESET_PC, 0, byte address loaded into pc on reset and on run.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- run  in  1  start pulse; honoured only in IDLE or HALT
- imem_we  in  1  program-load write strobe
- imem_waddr  in  $clog2(IMEM_DEPTH)  word address
- imem_wdata  in  32  instruction word
- busy  out  1  high in any state except IDLE and HALT
- halted  out  1  high in HALT
- trap  out  1  high in HALT when the halt was caused by a fault
- pc  out  XLEN  current instruction byte address
- wb_valid  out  1  one-cycle retire strobe
- wb_rd  out  5  destination index of the retiring instruction
- wb_data  out  XLEN  value written (link address for JAL/JALR; 0 for branches)
- retired  out  32  count of retired instructions

Interface decision: one clock, clk; rst is asynchronous and active-high. All flops, including the register file, clear on rst.

Behaviour:
- Reset values:
  - State IDLE; pc = RESET_PC.
  - busy, halted, trap, wb_valid = 0; wb_rd = 0; wb_data = 0; retired = 0.
  - All registers = 0. Instruction memory is not reset.
- States: IDLE, FETCH, DECODE, EXEC, MUL, WB, HALT.
- IDLE/HALT + run:
  - pc = RESET_PC; trap and retired clear; register file retains its contents.
  - Next state FETCH.
- FETCH: ir <= imem[pc[$clog2(IMEM_DEPTH)+1:2]]. Addresses wrap modulo depth.
- DECODE:
  - Latch rs1/rs2 values and the sign-extended immediate (I/S/B/U/J formats).
  - Fault if any used register index ≥ NUM_REGS.
- EXEC:
  - ALU result is computed in one cycle, then go to WB.
  - MUL (funct7 = 0000001, funct3 = 000) loads the multiplier and goes to MUL.
- MUL:
  - Exactly XLEN cycles, one partial-product bit per cycle.
  - Result is the low XLEN bits of the product, identical for signed and unsigned operands.
  - Then WB.
- WB:
  - Write rd if rd != 0; x0 always reads 0.
  - Pulse wb_valid and increment retired (wraps at 2^32).
  - Update pc, then go to FETCH.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL.
  - Shift amount uses the low $clog2(XLEN) bits.
- Latency: 4 cycles per non-MUL instruction (FETCH to WB inclusive); 4 + XLEN cycles per MUL.
- pc update: pc+4 by default; taken branch or JAL: pc+imm; JALR: (rs1+imm) & ~1. All arithmetic is modulo 2^XLEN.
- Faults: EXEC goes to HALT with trap = 1, no writeback, and retired is unchanged. Fault conditions:
  - Unsupported opcode.
  - Unsupported funct3/funct7 encoding, including MULH/DIV/REM.
  - Register index ≥ NUM_REGS.
  - Taken control-transfer target with bit 1 set.
- ECALL/EBREAK (opcode 1110011): HALT with trap = 0, not counted as retired.
- imem writes:
  - Accepted only in IDLE or HALT; ignored while busy.
  - A write and run in the same cycle: the write lands first, so FETCH sees the new word.
- rst mid-instruction (including mid-MUL) aborts immediately to reset values.
- run while busy is ignored.

Test Plan:
- Load ADDI x1,x0,5; ADDI x2,x1,-7; EBREAK; pulse run -> wb_valid at cycles 4 and 8 with wb_data 5 then 0xFFFFFFFE. Then halted = 1, trap = 0, retired = 2.
- x1 = 7, x2 = 0xFFFFFFFD; MUL x3,x1,x2 -> wb_data 0xFFFFFFEB exactly 36 cycles after FETCH entry (XLEN = 32).
- BNE x0,x1,+8 with x1 = 1 at pc 8 -> next fetch pc 16. With x1 = 0 -> pc 12. Branch retire wb_data = 0.
- JALR x5,x1,1 with x1 = 0x20 -> x5 = pc+4, pc = 0x20. JAL with offset 6 -> trap = 1, halted = 1, no wb_valid.
- NUM_REGS = 16: ADD x17,x1,x2 -> trap; DIV encoding -> trap; ADDI x0,x0,9 -> x0 still reads 0.
- Assert rst during cycle 10 of a MUL -> all outputs return to reset values. imem_we while busy does not alter the program, verified on rerun.
